// File: rtl/hs_rr_arbiter_if.sv
// Handshake bundle between the four requesters, the arbiter and the downstream sink.
interface hs_rr_arbiter_if #(
  parameter int WIDTH = 32
) ();
  logic [3:0]         en_i;
  logic [4*WIDTH-1:0] data_i;
  logic [3:0]         rdy_to_send;
  logic               en_o;
  logic [WIDTH-1:0]   data_out;
  logic [1:0]         src_o;
  logic               rdy_to_recieve;

  // master: the side that drives the requesters and the sink ready
  modport master (
    output en_i, data_i, rdy_to_recieve,
    input  rdy_to_send, en_o, data_out, src_o
  );

  modport slave (
    input  en_i, data_i, rdy_to_recieve,
    output rdy_to_send, en_o, data_out, src_o
  );
endinterface

// File: rtl/hs_rr_arbiter.sv
// Four-way round-robin valid/ready arbiter feeding a single registered output slot.
// Optional macro HS_ARB_BURST_EN keeps a grant for up to BURST back-to-back transfers.
module hs_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         en_i,
  input  logic [4*WIDTH-1:0] data_i,
  output logic [3:0]         rdy_to_send,
  output logic               en_o,
  output logic [WIDTH-1:0]   data_out,
  output logic [1:0]         src_o,
  input  logic               rdy_to_recieve
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       cand [4];
  logic [3:0]       hit;
  logic [1:0]       rr_grant;
  logic             rr_found;
  logic [1:0]       grant;
  logic             req;
  logic             load_ok;
  logic             up_xfer;

  if (BURST < 1 || BURST > 15) begin : g_burst_range
    $error("hs_rr_arbiter: BURST must be in 1..15");
  end

  // cand[0] is the highest-priority requester: the one right after the last grant
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand[gi] = last_q + 2'(gi + 1);
    assign hit[gi]  = en_i[cand[gi]];
  end

  always_comb begin
    rr_grant = last_q;
    rr_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) begin
        rr_grant = cand[k];
        rr_found = 1'b1;
      end
    end
  end

`ifdef HS_ARB_BURST_EN
  logic [3:0] burst_q, burst_d;
  logic [3:0] burst_inc;
  logic       lock;

  // A non-zero count means the previous transfer opened or extended a lock
  assign lock      = (burst_q != 4'd0) && en_i[last_q];
  assign grant     = lock ? last_q : rr_grant;
  assign req       = lock | rr_found;
  assign burst_inc = (lock ? burst_q : 4'd0) + 4'd1;

  always_comb begin
    burst_d = lock ? burst_q : 4'd0;
    if (up_xfer) begin
      burst_d = (burst_inc == 4'(BURST)) ? 4'd0 : burst_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) burst_q <= 4'd0;
    else     burst_q <= burst_d;
  end
`else
  assign grant = rr_grant;
  assign req   = rr_found;
`endif

  assign load_ok     = (state_q == EMPTY) | rdy_to_recieve;
  assign rdy_to_send = (!rst && load_ok && req) ? (4'b0001 << grant) : 4'b0000;
  assign up_xfer     = |(en_i & rdy_to_send);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (up_xfer) begin
      state_d = FULL;
      data_d  = data_i[int'(grant)*WIDTH +: WIDTH];
      src_d   = grant;
      last_d  = grant;
    end else if (state_q == FULL && rdy_to_recieve) begin
      state_d = EMPTY;
    end
  end

  // last_q resets to 3 so requester 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign en_o     = (state_q == FULL);
  assign data_out = data_q;
  assign src_o    = src_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Table-driven bench for hs_rr_arbiter with a scoreboard of expected output words.
module tb_hs_rr_arbiter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hs_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  hs_rr_arbiter #(.WIDTH(WIDTH), .BURST(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_i           (bus.en_i),
    .data_i         (bus.data_i),
    .rdy_to_send    (bus.rdy_to_send),
    .en_o           (bus.en_o),
    .data_out       (bus.data_out),
    .src_o          (bus.src_o),
    .rdy_to_recieve (bus.rdy_to_recieve)
  );

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       rdy;
    logic [7:0] base;
    logic [3:0] exp_rts;
    logic       exp_en_o;
    logic       chk_en;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       src;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(logic r, logic [3:0] e, logic rd, logic [7:0] b,
                              logic [3:0] rts, logic eo, logic ce);
    vec_t v;
    v.rst = r; v.en = e; v.rdy = rd; v.base = b;
    v.exp_rts = rts; v.exp_en_o = eo; v.chk_en = ce;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int row, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [3:0] e, logic rd, logic [7:0] b);
    rst                = r;
    bus.en_i           = e;
    bus.rdy_to_recieve = rd;
    bus.data_i         = {WIDTH'(b + 8'd3), WIDTH'(b + 8'd2), WIDTH'(b + 8'd1), WIDTH'(b)};
  endtask

  initial begin
    vec_t v;
    exp_t cur;
    exp_t ne;
    logic have = 1'b0;
    logic prev_rst = 1'b0;
    logic got;

    add(1, 4'b1111, 1, 8'h10, 4'b0000, 0, 0);
    add(1, 4'b1111, 1, 8'h10, 4'b0000, 0, 1);
`ifdef HS_ARB_BURST_EN
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 1, 8'h10, 4'b0001, i != 0, 1);
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 1, 8'h10, 4'b0010, 1, 1);
    add(0, 4'b0011, 1, 8'h10, 4'b0001, 1, 1);
    add(0, 4'b0011, 1, 8'h10, 4'b0001, 1, 1);
    add(0, 4'b0010, 1, 8'h10, 4'b0010, 1, 1);
    add(0, 4'b0000, 1, 8'h10, 4'b0000, 1, 1);
    add(0, 4'b0000, 1, 8'h10, 4'b0000, 0, 1);
`else
    // round-robin stream over all four requesters
    add(0, 4'b1111, 1, 8'h10, 4'b0001, 0, 1);
    add(0, 4'b1111, 1, 8'h10, 4'b0010, 1, 1);
    add(0, 4'b1111, 1, 8'h10, 4'b0100, 1, 1);
    add(0, 4'b1111, 1, 8'h10, 4'b1000, 1, 1);
    add(0, 4'b1111, 1, 8'h10, 4'b0001, 1, 1);
    // load 0x21 then stall three cycles
    add(0, 4'b1111, 1, 8'h20, 4'b0010, 1, 1);
    add(0, 4'b1111, 0, 8'h20, 4'b0000, 1, 1);
    add(0, 4'b1111, 0, 8'h20, 4'b0000, 1, 1);
    add(0, 4'b1111, 0, 8'h20, 4'b0000, 1, 1);
    add(0, 4'b1111, 1, 8'h20, 4'b0100, 1, 1);
    // single requester 2
    add(0, 4'b0100, 1, 8'h53, 4'b0100, 1, 1);
    add(0, 4'b0100, 1, 8'h53, 4'b0100, 1, 1);
    add(0, 4'b0100, 1, 8'h53, 4'b0100, 1, 1);
    // wrap-around
    add(0, 4'b1000, 1, 8'h30, 4'b1000, 1, 1);
    add(0, 4'b0001, 1, 8'h30, 4'b0001, 1, 1);
    add(0, 4'b1001, 1, 8'h30, 4'b1000, 1, 1);
    add(0, 4'b0000, 1, 8'h30, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 8'h30, 4'b0000, 0, 1);
    // load 0x77, hold, then reset while full
    add(0, 4'b1111, 0, 8'h77, 4'b0001, 0, 1);
    add(0, 4'b0000, 0, 8'h77, 4'b0000, 1, 1);
    add(1, 4'b1111, 0, 8'h77, 4'b0000, 1, 1);
    add(0, 4'b1111, 1, 8'h40, 4'b0001, 0, 1);
    add(0, 4'b0000, 1, 8'h40, 4'b0000, 1, 1);
    add(0, 4'b0000, 1, 8'h40, 4'b0000, 0, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.rst, v.en, v.rdy, v.base);
      #1;
      if (sb.size() > 0) begin
        cur  = sb.pop_front();
        have = 1'b1;
      end
      chk("rdy_to_send", i, WIDTH'(bus.rdy_to_send), WIDTH'(v.exp_rts));
      if (v.chk_en) chk("en_o", i, WIDTH'(bus.en_o), WIDTH'(v.exp_en_o));
      if (prev_rst) begin
        chk("reset data_out", i, bus.data_out, '0);
        chk("reset src_o", i, WIDTH'(bus.src_o), '0);
      end else if (v.exp_en_o && have) begin
        chk("data_out", i, bus.data_out, cur.data);
        chk("src_o", i, WIDTH'(bus.src_o), WIDTH'(cur.src));
      end
      if (v.rst) begin
        sb.delete();
        have = 1'b0;
      end else if (v.exp_rts != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (v.exp_rts[k]) begin
            ne.data = WIDTH'(v.base + 8'(k));
            ne.src  = 2'(k);
          end
        end
        sb.push_back(ne);
      end
      prev_rst = v.rst;
    end

    // single word from requester 2, waited for with a cycle budget
    @(negedge clk);
    drive(0, 4'b0100, 1, 8'h53);
    #1;
    chk("late rdy_to_send", -1, WIDTH'(bus.rdy_to_send), WIDTH'(4'b0100));
    @(negedge clk);
    drive(0, 4'b0000, 0, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (bus.en_o) got = 1'b1;
      else @(negedge clk);
    end
    chk("late en_o within budget", -1, WIDTH'(got), WIDTH'(1));
    chk("late data_out", -1, bus.data_out, WIDTH'(8'h55));
    chk("late src_o", -1, WIDTH'(bus.src_o), WIDTH'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
